// File: rtl/writeback_scoreboard_if.sv
// writeback_scoreboard_if: issue-side and writeback-side signals of the scoreboard
interface writeback_scoreboard_if #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS = 64
);
  localparam int WIDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int RW = $clog2(NUM_REGS);
  logic ib_valid;
  logic ib_ready;
  logic [WIDW-1:0] ib_wid;
  logic ib_wb;
  logic [RW-1:0] ib_rd;
  logic [RW-1:0] ib_rs1;
  logic [RW-1:0] ib_rs2;
  logic [RW-1:0] ib_rs3;
  logic disp_ready;
  logic wb_valid;
  logic [WIDW-1:0] wb_wid;
  logic [RW-1:0] wb_rd;
  logic wb_eop;
  modport master (
    output ib_valid, ib_wid, ib_wb, ib_rd, ib_rs1, ib_rs2, ib_rs3, disp_ready,
    output wb_valid, wb_wid, wb_rd, wb_eop,
    input ib_ready
  );
  modport slave (
    input ib_valid, ib_wid, ib_wb, ib_rd, ib_rs1, ib_rs2, ib_rs3, disp_ready,
    input wb_valid, wb_wid, wb_rd, wb_eop,
    output ib_ready
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard: tracks per-warp destination registers in flight between issue and writeback
module writeback_scoreboard #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS = 64,
  parameter int STALL_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  writeback_scoreboard_if.slave sb,
  output logic [NUM_WARPS-1:0] warp_busy,
  output logic spurious_wb,
  output logic deadlock
);
  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse;
  logic [NUM_REGS-1:0] set_m;
  logic [NUM_REGS-1:0] clr_m;
  logic [CW-1:0] stall_cnt;
  logic hazard;
  logic fire;
  logic blocked;
  logic wb_eop_v;
  // bit 0 of every warp is never set, so x0 can never create a hazard
  always_comb begin
    hazard = inuse[sb.ib_wid][sb.ib_rs1] | inuse[sb.ib_wid][sb.ib_rs2] |
             inuse[sb.ib_wid][sb.ib_rs3] | (sb.ib_wb & inuse[sb.ib_wid][sb.ib_rd]);
    sb.ib_ready = sb.disp_ready & ~hazard;
    fire = sb.ib_valid & sb.ib_ready;
    blocked = sb.ib_valid & ~sb.ib_ready;
    wb_eop_v = sb.wb_valid & sb.wb_eop & (sb.wb_rd != '0);
    set_m = (fire & sb.ib_wb) ? NUM_REGS'(1) << sb.ib_rd : '0;
    clr_m = wb_eop_v ? NUM_REGS'(1) << sb.wb_rd : '0;
    warp_busy = '0;
    for (int i = 0; i < NUM_WARPS; i++) warp_busy[i] = |inuse[i];
  end
  // set is applied after clear so a same-edge collision leaves the register pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inuse <= '0;
      stall_cnt <= '0;
      spurious_wb <= 1'b0;
      deadlock <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++)
        inuse[i] <= ((inuse[i] & ~((32'(sb.wb_wid) == i) ? clr_m : '0)) |
                     ((32'(sb.ib_wid) == i) ? set_m : '0)) & ~NUM_REGS'(1);
      stall_cnt <= !blocked ? '0 : (stall_cnt == CW'(STALL_TIMEOUT)) ? stall_cnt : stall_cnt + 1'b1;
      spurious_wb <= spurious_wb | (wb_eop_v & ~inuse[sb.wb_wid][sb.wb_rd]);
      deadlock <= deadlock | (blocked && stall_cnt >= CW'(STALL_TIMEOUT - 1));
    end
  end
  a_ib_wid: assert property (@(posedge clk) disable iff (!reset) sb.ib_valid |-> 32'(sb.ib_wid) < NUM_WARPS);
  a_wb_wid: assert property (@(posedge clk) disable iff (!reset) sb.wb_valid |-> 32'(sb.wb_wid) < NUM_WARPS);
endmodule
